sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   Holds a frame of hex nibbles and steps one digit per slot. Drives a single shared hex decoder: active-low segments, abc_defg order.
//   Inserts dead time between digits to suppress ghosting.
//   Commits newly loaded data only at frame boundaries, so a frame never shows a mix of old and new digits.
//   Sits between the PS/2 keycode path and the board display pins.
// PARAMETERS
//   N_DIGITS     4      digits scanned; i_data is 4*N_DIGITS wide
//   PRESCALE     50000  i_clk cycles per digit slot; >=2
//   DEAD_CYCLES  16     blanked cycles at the start of each slot; must be < PRESCALE
// PORTS
//   i_clk        in   1           system clock; all state changes on rising edge
//   i_reset      in   1           asynchronous, active-high reset
//   i_load       in   1           1-cycle strobe: capture i_data into shadow register
//   i_data       in   4*N_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
//   i_digit_en   in   N_DIGITS    per-digit enable; 0 = digit kept dark
//   o_anodes     out  N_DIGITS    active-low digit select; bit k = digit k
//   o_segments   out  7           active-low segments, abc_defg order
//   o_frame      out  1           1-cycle pulse at each frame start (digit 0 slot begins)
//   o_pending    out  1           shadow data loaded but not yet committed
// BEHAVIOUR
//   Reset (async, immediate): shadow=0, disp=0, o_pending=0, digit idx=0, slot cnt=0, state=BLANK;
//     o_anodes=all 1, o_segments=7'b111_1111, o_frame=0.
//   Slot counter: runs 0..PRESCALE-1, then wraps to 0. On wrap, idx advances; idx N_DIGITS-1 wraps to 0.
//   FSM: BLANK while cnt<DEAD_CYCLES, SHOW while cnt>=DEAD_CYCLES.
//     BLANK: all anodes high, segments 7'b111_1111.
//     SHOW: anode[idx]=0 only if i_digit_en[idx]=1; segments = decode(disp[4*idx+:4]).
//   Disabled digit: still consumes its slot; anodes all high and segments all 1 for the whole slot.
//   Decode table (abc_defg), 0..F:
//     0000001 1001111 0010010 0000110 1001100 0100100 0100000 0001111
//     0000000 0001100 0001000 1100000 0110001 1000010 0110000 0111000
//   Output latency: o_anodes/o_segments registered, 1 cycle after the internal state/cnt they reflect.
//   Load: i_load=1 -> next cycle shadow=i_data, o_pending=1. Repeated loads before commit: last load wins.
//   Commit: on the cycle idx wraps to 0 -> disp=shadow if pending; pending cleared; o_frame=1 for that one cycle.
//     o_frame pulses every frame, whether or not a commit occurs.
//   Load and commit in the same cycle: commit takes the pre-load shadow; the new data stays in shadow; o_pending stays 1.
//   i_data is ignored when i_load=0. disp never changes mid-frame.
//   Reset mid-slot: outputs blank at once; scan restarts at digit 0 in BLANK; pending data lost.
// CONFIGURATION
//   SEVENSEG_LZB_EN defined: leading-zero blanking. Digit k (k>0) is dark when disp nibbles k..N_DIGITS-1 are all 0.
//     Dark = anodes high, segments 7'b111_1111. Digit 0 is never blanked by this rule.
//   SEVENSEG_LZB_EN undefined: every enabled digit is shown, including leading zeros.
//   All other behaviour is identical in both builds.
// TESTING  (N_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2, i_digit_en=4'b1111 unless stated)
//   T1 reset: assert i_reset mid-SHOW of digit 2 -> o_anodes=4'b1111, o_segments=7'h7F before the next edge.
//      Release -> first SHOW is digit 0 at cnt=2 (+1 cycle latency).
//   T2 load/decode: i_load with 16'h1234, then run two frames. After commit:
//      digit0 anodes=1110 seg=1001100; digit1 1101/0000110; digit2 1011/0010010; digit3 0111/1001111.
//   T3 no tearing: 16'hAAAA displayed; load 16'h5555 during digit 1 slot.
//      Digits 2,3 still show A (0001000); o_pending=1 until o_frame.
//      Next frame all show 5 (0100100); o_pending=0.
//   T4 dead time + collision: every slot has 2 cycles of anodes=1111, segments=7F.
//      i_load on the o_frame cycle -> old shadow committed; o_pending stays 1; new value shown one frame later.
//   T5 digit enable: i_digit_en=4'b0101 over 3 frames -> anode bits 1 and 3 never 0.
//      Frame length stays 32 cycles (o_frame period 32).
//   T6 LZB, with macro: 16'h0050 -> digits 3,2 dark; digit1 shows 5; digit0 shows 0.
//      16'h0000 -> only digit0 lit (0000001).
//      Without macro: both values light all four digits.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [4*N_DIGITS-1:0]   i_data,
  input  logic [N_DIGITS-1:0]     i_digit_en,
  output logic [N_DIGITS-1:0]     o_anodes,
  output logic [6:0]              o_segments,
  output logic                    o_frame,
  output logic                    o_pending
);

  localparam int unsigned DATA_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                slot_wrap, frame_wrap;
  logic [DATA_W-1:0]   shadow, disp;
  logic [N_DIGITS-1:0] lzb_dark;
  logic [3:0]          nibble;
  logic                lit;

  // Shared hex decoder, active-low abc_defg.
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'b0000001;
      4'h1: hex_decode = 7'b1001111;
      4'h2: hex_decode = 7'b0010010;
      4'h3: hex_decode = 7'b0000110;
      4'h4: hex_decode = 7'b1001100;
      4'h5: hex_decode = 7'b0100100;
      4'h6: hex_decode = 7'b0100000;
      4'h7: hex_decode = 7'b0001111;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0001100;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b1100000;
      4'hC: hex_decode = 7'b0110001;
      4'hD: hex_decode = 7'b1000010;
      4'hE: hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    slot_wrap  = (cnt == CNT_LAST);
    frame_wrap = slot_wrap && (idx == IDX_LAST);
    cnt_nxt    = slot_wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt    = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    state_nxt  = (cnt_nxt < CNT_DEAD) ? BLANK : SHOW;
  end

  // Digit k>0 goes dark when it and every more-significant nibble is zero.
  always_comb begin
    lzb_dark = '0;
`ifdef SEVENSEG_LZB_EN
    begin : lzb
      logic zero_run;
      zero_run = 1'b1;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
        zero_run    = zero_run && (disp[4*k +: 4] == 4'h0);
        lzb_dark[k] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    nibble = 4'(disp >> {idx, 2'b00});
    lit    = (state == SHOW) && i_digit_en[idx] && !lzb_dark[idx];
  end

  // o_frame is high during the cycle whose closing edge wraps to digit 0 and commits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      o_pending  <= 1'b0;
      o_frame    <= 1'b0;
      o_anodes   <= '1;
      o_segments <= 7'h7F;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      o_frame <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

      if (frame_wrap && o_pending) disp <= shadow;
      if (i_load) begin
        shadow    <= i_data;
        o_pending <= 1'b1;
      end else if (frame_wrap) begin
        o_pending <= 1'b0;
      end

      if (lit) begin
        o_anodes   <= ~(N_DIGITS'(1) << idx);
        o_segments <= hex_decode(nibble);
      end else begin
        o_anodes   <= '1;
        o_segments <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl; the reference model derives each cycle's
// expected outputs from the cycle number and the recorded input history.
module tb_sevenseg_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int D  = 2;
  localparam int PN = P * N;

  logic        clk = 1'b0;
  logic        i_reset, i_load;
  logic [15:0] i_data;
  logic [3:0]  i_digit_en;
  logic [3:0]  o_anodes;
  logic [6:0]  o_segments;
  logic        o_frame, o_pending;

  sevenseg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(D)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_load(i_load), .i_data(i_data),
    .i_digit_en(i_digit_en), .o_anodes(o_anodes), .o_segments(o_segments),
    .o_frame(o_frame), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
    logic       pend;
  } exp_t;

  exp_t        exp_q[$];
  bit          ld_h[$];
  logic [15:0] dat_h[$];
  logic [3:0]  en_h[$];
  logic [6:0]  dec [16];
  int          cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // First internal frame in which a load issued during cycle j is displayed.
  function automatic int shown_frame(input int j);
    return (j + 1) / PN + 1;
  endfunction

  function automatic exp_t model(input int c);
    exp_t        e;
    int          q, cnt, dig, fr;
    logic [15:0] disp;
    logic [3:0]  nib;
    bit          dark;
    e.cyc = c; e.an = 4'hF; e.seg = 7'h7F; e.frame = 1'b0; e.pend = 1'b0;
    if (c == 0) return e;
    e.frame = ((c % PN) == PN - 1);
    for (int j = 0; j < c; j++)
      if (ld_h[j] && shown_frame(j) > c / PN) e.pend = 1'b1;
    q = c - 1; cnt = q % P; dig = (q / P) % N; fr = q / PN;
    disp = 16'h0;
    for (int j = 0; j < c; j++)
      if (ld_h[j] && shown_frame(j) <= fr) disp = dat_h[j];
    dark = (cnt < D) || !en_h[q][dig];
`ifdef SEVENSEG_LZB_EN
    if (dig > 0 && (disp >> (4 * dig)) == 16'h0) dark = 1'b1;
`endif
    if (!dark) begin
      nib   = 4'((disp >> (4 * dig)) & 16'hF);
      e.an  = ~(4'b0001 << dig);
      e.seg = dec[nib];
    end
    return e;
  endfunction

  // Apply this cycle's inputs, record them, and queue the expected outputs.
  task automatic drive_cycle(input bit ld, input logic [15:0] d, input logic [3:0] en);
    exp_q.push_back(model(cyc));
    i_load = ld; i_data = d; i_digit_en = en;
    ld_h.push_back(ld); dat_h.push_back(d); en_h.push_back(en);
    cyc++;
  endtask

  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] en);
    @(posedge clk); #1;
    drive_cycle(ld, d, en);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    i_reset = 1'b0;
    ld_h.delete(); dat_h.delete(); en_h.delete();
    cyc = 0;
    drive_cycle(1'b0, 16'h0, 4'hF);
  endtask

  always @(negedge clk) begin
    if (!i_reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val($sformatf("scan_c%0d", e.cyc), {21'h0, o_anodes, o_segments, o_frame, o_pending},
                {21'h0, e.an, e.seg, e.frame, e.pend});
    end
  end

  initial begin
    bit          ld;
    logic [15:0] d;
    logic [3:0]  en_r;
    dec = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    i_reset = 1'b1; i_load = 1'b0; i_data = '0; i_digit_en = 4'hF; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_anodes", {28'h0, o_anodes}, 32'hF);
    check_val("reset_segments", {25'h0, o_segments}, 32'h7F);
    release_reset();

    // Run into the SHOW part of digit 2 with a load pending, then reset asynchronously.
    for (int c = 1; c <= 20; c++) step(c == 5, 16'h8888, 4'hF);
    @(posedge clk); #1;
    i_reset = 1'b1; i_load = 1'b0;
    #1;
    check_val("async_anodes", {28'h0, o_anodes}, 32'hF);
    check_val("async_segments", {25'h0, o_segments}, 32'h7F);
    check_val("async_pending", {31'h0, o_pending}, 32'h0);
    check_val("async_frame", {31'h0, o_frame}, 32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    en_r = 4'hF;
    for (int c = 1; c < 700; c++) begin
      ld = 1'b0; d = 16'($urandom);
      if (c >= 260 && c < 360) en_r = 4'b0101;
      else if (c >= 360 && (c % 32) == 5) en_r = 4'($urandom);
      else if (c < 360) en_r = 4'hF;
      case (c)
        3:   begin ld = 1'b1; d = 16'h1234; end
        97:  begin ld = 1'b1; d = 16'hAAAA; end
        138: begin ld = 1'b1; d = 16'h5555; end
        190: begin ld = 1'b1; d = 16'h0050; end
        210: begin ld = 1'b1; d = 16'hC0DE; end
        223: begin ld = 1'b1; d = 16'h0000; end
        300: begin ld = 1'b1; d = 16'h0050; end
        default: if (c >= 360) ld = (($urandom % 12) == 0);
      endcase
      step(ld, d, en_r);
    end
    step(1'b0, 16'h0, en_r);
    repeat (2) @(negedge clk);
    check_val("queue_drain", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
